// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared widths, state and index types for the dmem arbiter.
package dmem_arb_pkg;
    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 32;
    localparam int BURST_CNT_W = 8;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
    typedef logic port_idx_t;
endpackage

// File: rtl/dmem_rr_picker.sv
// dmem_rr_picker: two-way round-robin pick, favouring the port that did not win last.
module dmem_rr_picker
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last_winner,
    output logic [1:0] winner,
    output logic       any_req
);
    always_comb begin
        winner[0] = req[0] & (~req[1] | last_winner);
        winner[1] = req[1] & (~req[0] | ~last_winner);
        any_req   = |req;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of single-port dmem with capped locked bursts.
// Define DMEM_ARB_STATS_EN to add the conflict_cnt port and counter.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wren,
    input  logic              m1_wren,
    input  logic              m0_lock,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);
    localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_BURST);

    arb_state_t             state_q, state_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    port_idx_t              last_winner_q, last_winner_d;
    logic [1:0]             rvalid_q, rvalid_d;
    logic [1:0]             req, lock, wr, win, gnt;
    logic                   any_req;
    port_idx_t              own;

    assign req  = {m1_req, m0_req};
    assign lock = {m1_lock, m0_lock};
    assign wr   = {m1_wren, m0_wren};
    assign own  = port_idx_t'(state_q == OWN1);

    dmem_rr_picker u_picker (
        .req        (req),
        .last_winner(last_winner_q),
        .winner     (win),
        .any_req    (any_req)
    );

    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        last_winner_d = last_winner_q;
        gnt           = 2'b00;
        if (state_q == IDLE) begin
            gnt           = win;
            last_winner_d = any_req ? port_idx_t'(win[1]) : last_winner_q;
            if (|(win & lock)) begin
                state_d     = win[1] ? OWN1 : OWN0;
                burst_cnt_d = BURST_CNT_W'(1);
            end
        end else begin
            gnt[own]    = req[own];
            burst_cnt_d = (burst_cnt_q == MAX_CNT) ? burst_cnt_q : burst_cnt_q + BURST_CNT_W'(req[own]);
            // Release on the grant that reaches the cap, so the waiting port wins the very next cycle.
            if (!req[own] || !lock[own] || (burst_cnt_d == MAX_CNT && req[~own])) begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        end
        gnt      = reset ? 2'b00 : gnt;
        rvalid_d = gnt & ~wr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            burst_cnt_q   <= '0;
            last_winner_q <= 1'b1;
            rvalid_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            last_winner_q <= last_winner_d;
            rvalid_q      <= rvalid_d;
        end
    end

    assign m0_gnt       = gnt[0];
    assign m1_gnt       = gnt[1];
    assign m0_rvalid    = rvalid_q[0];
    assign m1_rvalid    = rvalid_q[1];
    assign m0_rdata     = rvalid_q[0] ? q_dmem : '0;
    assign m1_rdata     = rvalid_q[1] ? q_dmem : '0;
    assign address_dmem = gnt[1] ? m1_addr : gnt[0] ? m0_addr : '0;
    assign data         = gnt[1] ? m1_wdata : gnt[0] ? m0_wdata : '0;
    assign wren         = |(gnt & wr);

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    assign conflict_cnt_d = (|(req & ~gnt) && conflict_cnt_q != 16'hFFFF) ? conflict_cnt_q + 16'd1 : conflict_cnt_q;
    assign conflict_cnt   = conflict_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) conflict_cnt_q <= '0;
        else conflict_cnt_q <= conflict_cnt_d;
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with grant/read scoreboards checked by a negedge monitor.
module tb_dmem_arbiter;
    typedef struct {
        int          port;
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } g_t;
    typedef struct {
        int          port;
        logic [31:0] data;
    } r_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_wren, m1_wren, m0_lock, m1_lock;
    logic [11:0] m0_addr, m1_addr, address_dmem;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, data, q_dmem;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, wren;
    logic [31:0] mem [0:4095];
    g_t          gq[$];
    r_t          rq[$];
    int          errors = 0;
    int          checks = 0;
    logic        done, chk_m1_zero;
    logic [1:0]  prev_rd = 2'b00;
    logic [1:0]  g, rv;
    logic [45:0] p0_f, p1_f;
    logic        p0_wait = 1'b0, p1_wait = 1'b0;
    g_t          ge;
    r_t          re;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic        chk_cc;
`endif

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_wren(m0_wren), .m1_wren(m1_wren),
        .m0_lock(m0_lock), .m1_lock(m1_lock), .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
`ifdef DMEM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clock = ~clock;

    // dmem model: write-first, one-cycle read latency, two known words preloaded while in reset.
    always @(posedge clock) begin
        if (reset) begin
            mem[12'h010] <= 32'hDEADBEEF;
            mem[12'h011] <= 32'hCAFEF00D;
        end else if (wren) begin
            mem[address_dmem] <= data;
        end
        q_dmem <= wren ? data : mem[address_dmem];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push_g(input int p, input logic [11:0] a, input logic w, input logic [31:0] d);
        g_t e;
        e.port = p; e.addr = a; e.wr = w; e.wdata = d;
        gq.push_back(e);
    endtask

    task automatic push_r(input int p, input logic [31:0] d);
        r_t e;
        e.port = p; e.data = d;
        rq.push_back(e);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
        m0_wren = 1'b0; m1_wren = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        g  = {m1_gnt, m0_gnt};
        rv = {m1_rvalid, m0_rvalid};
        check("gnt_onehot", {63'b0, g == 2'b11}, 64'd0);
        if (reset) check("reset_drive", {g, wren, address_dmem, data}, 64'd0);
        if (g != 2'b00) begin
            if (gq.size() == 0) begin
                check("unexpected_gnt", {62'b0, g}, 64'd0);
            end else begin
                ge = gq.pop_front();
                check("gnt_port", {62'b0, g}, (ge.port == 1) ? 64'd2 : 64'd1);
                check("gnt_addr", {52'b0, address_dmem}, {52'b0, ge.addr});
                check("gnt_wren", {63'b0, wren}, {63'b0, ge.wr});
                if (ge.wr) check("gnt_wdata", {32'b0, data}, {32'b0, ge.wdata});
            end
        end else begin
            check("idle_drive", {wren, address_dmem, data}, 64'd0);
        end
        check("rvalid_timing", {62'b0, rv}, reset ? 64'd0 : {62'b0, prev_rd});
        if (!rv[0]) check("m0_rdata_zero", {32'b0, m0_rdata}, 64'd0);
        if (!rv[1]) check("m1_rdata_zero", {32'b0, m1_rdata}, 64'd0);
        if (rv != 2'b00) begin
            if (rq.size() == 0) begin
                check("unexpected_rvalid", {62'b0, rv}, 64'd0);
            end else begin
                re = rq.pop_front();
                check("rvalid_port", {62'b0, rv}, (re.port == 1) ? 64'd2 : 64'd1);
                check("rdata", {32'b0, re.port == 1 ? m1_rdata : m0_rdata}, {32'b0, re.data});
            end
        end
        if (chk_m1_zero) check("m1_rvalid_after_reset", {63'b0, m1_rvalid}, 64'd0);
`ifdef DMEM_ARB_STATS_EN
        if (chk_cc) check("conflict_cnt", {48'b0, conflict_cnt}, 64'd5);
`endif
        // Requesters must hold their fields while waiting for a grant.
        if (!reset && p0_wait && m0_req) check("m0_fields_held", {18'b0, m0_wren, m0_lock, m0_addr, m0_wdata}, {18'b0, p0_f});
        if (!reset && p1_wait && m1_req) check("m1_fields_held", {18'b0, m1_wren, m1_lock, m1_addr, m1_wdata}, {18'b0, p1_f});
        p0_wait = m0_req & ~m0_gnt & ~reset;
        p1_wait = m1_req & ~m1_gnt & ~reset;
        p0_f    = {m0_wren, m0_lock, m0_addr, m0_wdata};
        p1_f    = {m1_wren, m1_lock, m1_addr, m1_wdata};
        prev_rd = reset ? 2'b00 : g & ~{m1_wren, m0_wren};
        if (done) begin
            check("gnt_queue_empty", 64'(gq.size()), 64'd0);
            check("rd_queue_empty", 64'(rq.size()), 64'd0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        done = 1'b0; chk_m1_zero = 1'b0;
`ifdef DMEM_ARB_STATS_EN
        chk_cc = 1'b0;
`endif
        reset = 1'b1;
        m0_wren = 1'b0; m1_wren = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
        m0_addr = 12'h010; m1_addr = 12'h011; m0_wdata = '0; m1_wdata = '0;
        m0_req = 1'b1; m1_req = 1'b0;
        tick;
        tick;
        reset = 1'b0; m0_req = 1'b0;
        // single m0 read of a preloaded word
        m0_req = 1'b1; m0_addr = 12'h010;
        push_g(0, 12'h010, 1'b0, '0); push_r(0, 32'hDEADBEEF);
        tick;
        m0_req = 1'b0;
        tick;
        tick;
        // both ports read continuously: strict alternation starting with m0
        do_reset;
        m0_req = 1'b1; m0_addr = 12'h010;
        m1_req = 1'b1; m1_addr = 12'h011;
        for (int i = 0; i < 6; i++) begin
            push_g(i % 2, (i % 2) ? 12'h011 : 12'h010, 1'b0, '0);
            push_r(i % 2, (i % 2) ? 32'hCAFEF00D : 32'hDEADBEEF);
        end
        repeat (5) tick;
`ifdef DMEM_ARB_STATS_EN
        chk_cc = 1'b1;
`endif
        tick;
`ifdef DMEM_ARB_STATS_EN
        chk_cc = 1'b0;
`endif
        m0_req = 1'b0; m1_req = 1'b0;
        tick;
        // m1 write then m0 read of the same address next cycle
        m1_req = 1'b1; m1_wren = 1'b1; m1_addr = 12'h020; m1_wdata = 32'h12345678;
        push_g(1, 12'h020, 1'b1, 32'h12345678);
        tick;
        m1_req = 1'b0; m1_wren = 1'b0;
        m0_req = 1'b1; m0_addr = 12'h020;
        push_g(0, 12'h020, 1'b0, '0); push_r(0, 32'h12345678);
        tick;
        m0_req = 1'b0;
        tick;
        // m0 locked burst against a persistent m1 request: 8 grants, then m1
        do_reset;
        m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 12'h010;
        m1_req = 1'b1; m1_addr = 12'h011;
        for (int i = 0; i < 8; i++) begin
            push_g(0, 12'h010, 1'b0, '0); push_r(0, 32'hDEADBEEF);
        end
        push_g(1, 12'h011, 1'b0, '0); push_r(1, 32'hCAFEF00D);
        repeat (9) tick;
        m0_req = 1'b0; m0_lock = 1'b0; m1_req = 1'b0;
        tick;
        tick;
        // reset right after a granted m1 read drops the response and refavours m0
        m1_req = 1'b1; m1_addr = 12'h011;
        push_g(1, 12'h011, 1'b0, '0);
        tick;
        m1_req = 1'b0; reset = 1'b1; chk_m1_zero = 1'b1;
        tick;
        chk_m1_zero = 1'b0; reset = 1'b0;
        m0_req = 1'b1; m0_addr = 12'h010;
        m1_req = 1'b1; m1_addr = 12'h011;
        push_g(0, 12'h010, 1'b0, '0); push_r(0, 32'hDEADBEEF);
        push_g(1, 12'h011, 1'b0, '0); push_r(1, 32'hCAFEF00D);
        tick;
        m0_req = 1'b0;
        tick;
        m1_req = 1'b0;
        tick;
        tick;
        done = 1'b1;
        tick;
        tick;
        $display("FAIL monitor_stalled: got no summary expected summary");
        $fatal(1, "monitor did not finish");
    end
endmodule
